apb_regbank: RTL and testbench

Parametrised APB4 completer that turns an APB bus into a bank of NUM_REGS memory-mapped registers. It adds byte strobes, configurable wait states, read-only registers, per-register hardware update ports and error signalling. It sits behind the APB master modport on a block's configuration path and exposes flat register outputs to the datapath.

---
 rtl/apb_regbank_pkg.sv | 29 ++
 rtl/apb_regbank_if.sv | 27 ++
 rtl/apb_regbank_wait_ctrl.sv | 66 ++++++
 rtl/apb_regbank.sv | 107 ++++++++++
 tb/tb_apb_regbank.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_regbank_pkg.sv
// Shared types and sizing helpers for the APB register bank.
// Holds the transfer-phase encoding and error-cause codes.
// Sizing helpers are evaluated at elaboration time only.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_RO
  } apb_err_e;

  // Bytes per register word.
  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  // Register index width, never narrower than one bit.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/apb_regbank_if.sv
// APB4 bus bundle between a requester and the register bank.
// Purely structural: no storage, no added latency.
// Backpressure is carried by pready from the completer side.
interface apb_regbank_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regbank_wait_ctrl.sv
// APB phase tracker and wait-state counter for the register bank.
// pready rises after WAIT_STATES access cycles (0 = first access cycle).
// Dropping psel/penable mid-access aborts the transfer without pready.
module apb_wait_ctrl
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_psel,
  input  logic i_penable,
  output logic o_pready,
  output logic o_access_active
);

  // state_q records the phase the bus was in on the previous cycle, so an
  // access cycle is recognised combinationally in the same cycle it appears.
  apb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        in_access;

  // Phase and wait-counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next phase, wait counting and pready generation.
  always_comb begin
    state_d   = IDLE;
    cnt_d     = '0;
    o_pready  = 1'b0;
    in_access = 1'b0;
    if (!i_rst) begin
      case (state_q)
        IDLE: begin
          if (i_psel && !i_penable) state_d = SETUP;
        end
        SETUP, ACCESS: begin
          if (i_psel && i_penable) begin
            in_access = 1'b1;
            if (cnt_q == 4'(WAIT_STATES)) begin
              o_pready = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = ACCESS;
              cnt_d   = cnt_q + 4'd1;
            end
          end else if (i_psel && !i_penable) begin
            // Either a held setup phase or an aborted access restarting.
            state_d = SETUP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    o_access_active = in_access;
  end

endmodule

// File: rtl/apb_regbank.sv
// APB4 completer exposing NUM_REGS byte-strobed registers plus HW update ports.
// Read data/response combinational in the pready cycle; wr_pulse one cycle later.
// Stalls the bus for WAIT_STATES cycles per access; HW writes never stall.
module apb_regbank
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]            RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  apb_regbank_if.slave                   apb,
  input  logic [NUM_REGS-1:0]            i_hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_hw_wdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
  output logic [NUM_REGS-1:0]            o_wr_pulse
);

  localparam int BYTES = bytes_of(DATA_WIDTH);
  localparam int IDXW  = idx_width(NUM_REGS);

  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IDXW-1:0]       idx;
  logic                  align_err, range_err, ro_hit, err, commit;
  logic                  pready, access_active;
  apb_err_e              err_cause;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait_ctrl (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_psel          (apb.psel),
    .i_penable       (apb.penable),
    .o_pready        (pready),
    .o_access_active (access_active)
  );

  // Address decode, error classification and read mux.
  always_comb begin
    idx_full  = apb.paddr / ADDR_WIDTH'(BYTES);
    idx       = idx_full[IDXW-1:0];
    align_err = (apb.paddr % ADDR_WIDTH'(BYTES)) != '0;
    // One extra bit so NUM_REGS == 2**ADDR_WIDTH does not wrap to zero.
    range_err = {1'b0, idx_full} >= (ADDR_WIDTH+1)'(NUM_REGS);
    ro_hit    = 1'b0;
    rd_dat    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (idx == IDXW'(r)) begin
        ro_hit = RO_MASK[r];
        rd_dat = regs_q[r];
      end
    end
    err_cause = ERR_NONE;
    if (access_active) begin
      if (align_err)                 err_cause = ERR_ALIGN;
      else if (range_err)            err_cause = ERR_RANGE;
      else if (apb.pwrite && ro_hit) err_cause = ERR_RO;
    end
    err = (err_cause != ERR_NONE);
  end

  assign apb.pready  = pready;
  assign apb.pslverr = pready & err;
  assign apb.prdata  = (pready && !apb.pwrite && !err) ? rd_dat : '0;

  // Register next-state: strobed APB commit, then HW write overrides it.
  always_comb begin
    commit     = pready & apb.pwrite & ~err;
    wr_pulse_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (commit && (idx == IDXW'(r))) begin
        wr_pulse_d[r] = 1'b1;
        for (int b = 0; b < BYTES; b++) begin
          if (apb.pstrb[b]) regs_d[r][8*b +: 8] = apb.pwdata[8*b +: 8];
        end
      end
      if (i_hw_we[r]) regs_d[r] = i_hw_wdata[r*DATA_WIDTH +: DATA_WIDTH];
      o_regs[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
    end
  end

  // Register storage and write-pulse flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= RESET_VAL[r*DATA_WIDTH +: DATA_WIDTH];
      end
      wr_pulse_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign o_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb_regbank.sv
// Self-checking bench for apb_regbank: two instances (0 and 3 wait states).
// Reference model is a plain array of register words updated per transfer.
// Bench-driven bus; every wait on the DUT is bounded.
module tb_apb_regbank;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam logic [NR-1:0]    RO = 4'b0100;
  localparam logic [NR*DW-1:0] RV = {32'hCAFE_0003, 32'h5A5A_0002,
                                     32'h0000_0101, 32'h1234_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0]    paddr;
  logic             psel, penable, pwrite;
  logic [DW-1:0]    pwdata;
  logic [DW/8-1:0]  pstrb;
  int               sel;
  logic [NR-1:0]    hw_we;
  logic [NR*DW-1:0] hw_wdata;

  logic [NR-1:0]    hw_we0, hw_we1, pulse0, pulse1, r_pulse;
  logic [NR*DW-1:0] regs0, regs1, r_regs;
  logic [DW-1:0]    r_prdata;
  logic             r_pready, r_pslverr;

  apb_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.paddr = paddr;  assign bus1.paddr = paddr;
  assign bus0.penable = penable;  assign bus1.penable = penable;
  assign bus0.pwrite = pwrite;  assign bus1.pwrite = pwrite;
  assign bus0.pwdata = pwdata;  assign bus1.pwdata = pwdata;
  assign bus0.pstrb = pstrb;  assign bus1.pstrb = pstrb;
  assign bus0.psel = psel & (sel == 0);
  assign bus1.psel = psel & (sel == 1);
  assign hw_we0 = (sel == 0) ? hw_we : '0;
  assign hw_we1 = (sel == 1) ? hw_we : '0;

  assign r_pready  = (sel == 1) ? bus1.pready  : bus0.pready;
  assign r_pslverr = (sel == 1) ? bus1.pslverr : bus0.pslverr;
  assign r_prdata  = (sel == 1) ? bus1.prdata  : bus0.prdata;
  assign r_regs    = (sel == 1) ? regs1 : regs0;
  assign r_pulse   = (sel == 1) ? pulse1 : pulse0;

  apb_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0),
                .RO_MASK(RO), .RESET_VAL(RV)) dut0 (
    .i_clk(clk), .i_rst(rst), .apb(bus0), .i_hw_we(hw_we0),
    .i_hw_wdata(hw_wdata), .o_regs(regs0), .o_wr_pulse(pulse0));

  apb_regbank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(3),
                .RO_MASK(RO), .RESET_VAL(RV)) dut1 (
    .i_clk(clk), .i_rst(rst), .apb(bus1), .i_hw_we(hw_we1),
    .i_hw_wdata(hw_wdata), .o_regs(regs1), .o_wr_pulse(pulse1));

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] mdl [2][NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < NR; r++) mdl[d][r] = RV[r*DW +: DW];
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < NR; r++) check(tag, r_regs[r*DW +: DW], mdl[sel][r]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"}, r_pready, 0);
    check({tag, "_err"}, r_pslverr, 0);
    check({tag, "_rd"}, r_prdata, 0);
    check({tag, "_pulse"}, r_pulse, 0);
  endtask

  // One complete APB transfer on instance d, with an optional HW write to
  // register hw_r presented in the same cycle that pready is seen.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [3:0] st,
                      input bit hw_en, input int hw_r, input logic [DW-1:0] hw_d,
                      output logic [DW-1:0] rd);
    int idx, waits;
    bit err, done;
    logic slverr;
    logic [DW-1:0] exp_rd;
    idx = int'(a) / 4;
    err = (a % 4 != 0) || (idx >= NR);
    if (!err && wr && RO[idx]) err = 1'b1;
    exp_rd = (!err && !wr) ? mdl[d][idx] : '0;
    rd = '0;
    slverr = 1'b0;
    sel = d;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    #1 check("setup_rdy", r_pready, 0);
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (r_pready) begin
        done = 1'b1;
        rd = r_prdata;
        slverr = r_pslverr;
        if (hw_en) begin
          hw_we = 4'(1 << hw_r);
          hw_wdata[hw_r*DW +: DW] = hw_d;
        end
      end else begin
        check("wait_err", r_pslverr, 0);
        waits++;
      end
    end
    check("rdy_seen", done, 1);
    check("wait_cnt", waits, (d == 1) ? 3 : 0);
    check("slverr", slverr, err);
    check("prdata", rd, exp_rd);
    if (!err && wr)
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    if (hw_en) mdl[d][hw_r] = hw_d;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; hw_we = '0;
    #1 check("wr_pulse", r_pulse, (!err && wr) ? 4'(1 << idx) : 4'h0);
    check_regs("regs");
    @(negedge clk);
    #1 check("pulse_once", r_pulse, 0);
  endtask

  // Transfer dropped after n_acc access cycles: no pready, no commit.
  task automatic abort_xfer(input int d, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int n_acc);
    sel = d;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    for (int k = 0; k < n_acc; k++) begin
      if (k > 0) @(negedge clk);
      #1 check("abort_rdy", r_pready, 0);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1 check("abort_rdy_after", r_pready, 0);
    @(negedge clk);
    #1 check("abort_pulse", r_pulse, 0);
    check_regs("abort_regs");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel = 0;
    hw_we = '0; hw_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #1 check_idle_outputs("reset");
      check_regs("reset_regs");
    end

    // Basic write then read back, zero wait states.
    xfer(0, 1, 16'h0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, rd);
    xfer(0, 0, 16'h0004, 0, 4'h0, 0, 0, 0, rd);
    check("rd_deadbeef", rd, 32'hDEAD_BEEF);

    // Byte strobes.
    xfer(0, 1, 16'h0000, 32'h1122_3344, 4'hF, 0, 0, 0, rd);
    xfer(0, 1, 16'h0000, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, rd);
    xfer(0, 0, 16'h0000, 0, 4'h0, 0, 0, 0, rd);
    check("rd_strobe", rd, 32'h11BB_33DD);
    xfer(0, 1, 16'h0000, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, rd);

    // Error responses: out of range, unaligned, read-only; RO read is fine.
    xfer(0, 1, 16'h0010, 32'h0BAD_0010, 4'hF, 0, 0, 0, rd);
    xfer(0, 1, 16'h0002, 32'h0BAD_0002, 4'hF, 0, 0, 0, rd);
    xfer(0, 1, 16'h0008, 32'h0BAD_0008, 4'hF, 0, 0, 0, rd);
    xfer(0, 0, 16'h0008, 0, 4'h0, 0, 0, 0, rd);
    check("rd_ro_reset", rd, 32'h5A5A_0002);
    xfer(0, 0, 16'h0010, 0, 4'h0, 0, 0, 0, rd);

    // Collision: HW write wins, pulse still fires.
    xfer(0, 1, 16'h000C, 32'h0000_0001, 4'hF, 1, 3, 32'h0000_0005, rd);
    check("collide_reg3", regs0[3*DW +: DW], 32'h0000_0005);

    // Wait states and protocol abort.
    xfer(1, 0, 16'h0004, 0, 4'h0, 0, 0, 0, rd);
    abort_xfer(1, 16'h0004, 32'h1357_9BDF, 1);
    abort_xfer(1, 16'h0000, 32'h2468_ACE0, 3);
    xfer(1, 1, 16'h0004, 32'h0F0F_0F0F, 4'hF, 0, 0, 0, rd);

    // Reset in the middle of an access.
    xfer(1, 1, 16'h0000, 32'h0000_00FF, 4'hF, 0, 0, 0, rd);
    sel = 1;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h77; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    #1 check("rst_mid_rdy", r_pready, 0);
    check("rst_mid_pulse", r_pulse, 0);
    check_regs("rst_mid_regs");
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);

    // Randomised traffic on both instances.
    for (int n = 0; n < 80; n++) begin
      int d, hw_r;
      bit wr, hw_en;
      logic [AW-1:0] a;
      d = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      if ($urandom_range(0, 9) < 7) a = AW'($urandom_range(0, NR - 1) * 4);
      else a = AW'($urandom_range(0, 19));
      hw_en = ($urandom_range(0, 3) == 0);
      hw_r = int'($urandom_range(0, NR - 1));
      xfer(d, wr, a, $urandom, 4'($urandom), hw_en, hw_r, $urandom, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
